// File: rtl/bpu_pkg.sv
// bpu_pkg: shared definitions for the branch prediction unit.
//   - 2-bit saturating counter encodings and the allocation value
//   - per-entry record used for the combinational lookup view
// The tag field is sized for the widest possible tag (IDX_BITS >= 0 gives a
// tag of at most 30 bits). Narrower tags are zero-extended into it.
package bpu_pkg;

  localparam logic [1:0] CNT_SNT   = 2'b00;
  localparam logic [1:0] CNT_WNT   = 2'b01;
  localparam logic [1:0] CNT_WT    = 2'b10;
  localparam logic [1:0] CNT_ST    = 2'b11;
  localparam logic [1:0] CNT_ALLOC = CNT_WT;

  localparam int TAG_W_MAX = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           cnt;
  } bpu_entry_t;

endpackage

// File: rtl/bpu_if.sv
// bpu_if: resolved-branch update bus from branch/commit logic into the BPU.
//   upd_valid   - a control-flow instruction resolved this cycle
//   upd_pc      - its PC
//   upd_taken   - actual direction
//   upd_target  - actual taken target
//   upd_mispred - resolution disagreed with prediction (statistics only)
// master: branch/commit side (drives). slave: bpu (samples).
interface bpu_if;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;

  modport master (output upd_valid, upd_pc, upd_taken, upd_target, upd_mispred);
  modport slave  (input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispred);
endinterface

// File: rtl/bpu_sat_cnt2.sv
// sat_cnt2: combinational next state of a 2-bit saturating counter.
//   cnt     in  current counter value
//   taken   in  1 = count up, 0 = count down
//   cnt_nxt out next value; holds at CNT_ST going up and CNT_SNT going down
module sat_cnt2
  import bpu_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_nxt
);
  always_comb begin
    cnt_nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_nxt = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_nxt = cnt - 2'd1;
    end
  end
endmodule

// File: rtl/bpu.sv
// bpu: direct-mapped BTB with a 2-bit direction counter per entry.
// Sits in front of the PC register and supplies its pr/pr_addr redirect.
//   clk, rst      clock, synchronous active-high reset (clears valid bits only)
//   pc_i          current fetch PC; bits [1:0] ignored
//   pr, pr_addr   same-cycle prediction; pr_addr is 0 whenever pr is 0
//   upd           bpu_if.slave resolved-branch training bus
//   perf_upd,     update / misprediction event counters, present only when
//   perf_mispred  the BPU_PERF_EN macro is defined
// Lookup reads pre-update state: a write in cycle N is seen from cycle N+1.
module bpu
  import bpu_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
`ifdef BPU_PERF_EN
  output logic [31:0] perf_upd,
  output logic [31:0] perf_mispred,
`endif
  input  logic [31:0] pc_i,
  output logic        pr,
  output logic [31:0] pr_addr,
  bpu_if.slave        upd
);
  localparam int TAG_BITS = 32 - IDX_BITS - 2;
  localparam int NUM      = 1 << IDX_BITS;

  logic [NUM-1:0]       valid_q, valid_d;
  logic [TAG_W_MAX-1:0] tag_q [NUM];
  logic [31:0]          tgt_q [NUM];
  logic [1:0]           cnt_q [NUM];

  // lookup
  logic [IDX_BITS-1:0]  l_idx;
  logic [TAG_W_MAX-1:0] l_tag;
  bpu_entry_t           l_e;
  logic                 l_hit;

  assign l_idx = pc_i[IDX_BITS+1:2];
  assign l_tag = TAG_W_MAX'(pc_i[31:IDX_BITS+2]);

  always_comb begin
    l_e.valid  = valid_q[l_idx];
    l_e.tag    = tag_q[l_idx];
    l_e.target = tgt_q[l_idx];
    l_e.cnt    = cnt_q[l_idx];
  end

  assign l_hit   = l_e.valid && (l_e.tag == l_tag);
  assign pr      = l_hit && l_e.cnt[1];
  assign pr_addr = pr ? l_e.target : 32'h0;

  // update
  logic [IDX_BITS-1:0]  u_idx;
  logic [TAG_W_MAX-1:0] u_tag;
  logic                 u_hit, u_alloc;
  logic [1:0]           u_cnt_nxt;

  assign u_idx   = upd.upd_pc[IDX_BITS+1:2];
  assign u_tag   = TAG_W_MAX'(upd.upd_pc[31:IDX_BITS+2]);
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  // not-taken misses never allocate, so cold/aliased entries stay untouched
  assign u_alloc = !u_hit && upd.upd_taken;

  sat_cnt2 u_cnt (
    .cnt     (cnt_q[u_idx]),
    .taken   (upd.upd_taken),
    .cnt_nxt (u_cnt_nxt)
  );

  always_comb begin
    valid_d = valid_q;
    if (upd.upd_valid && u_alloc) valid_d[u_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Payload arrays carry no reset; an update coincident with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && upd.upd_valid) begin
      if (u_hit) begin
        cnt_q[u_idx] <= u_cnt_nxt;
        if (upd.upd_taken) tgt_q[u_idx] <= upd.upd_target;
      end else if (u_alloc) begin
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= upd.upd_target;
        cnt_q[u_idx] <= CNT_ALLOC;
      end
    end
  end

`ifdef BPU_PERF_EN
  logic [31:0] perf_upd_q, perf_mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_upd_q <= '0;
      perf_mis_q <= '0;
    end else if (upd.upd_valid) begin
      perf_upd_q <= perf_upd_q + 32'd1;
      if (upd.upd_mispred) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_upd     = perf_upd_q;
  assign perf_mispred = perf_mis_q;

  logic unused_bits;
  assign unused_bits = ^{pc_i[1:0], upd.upd_pc[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{pc_i[1:0], upd.upd_pc[1:0], upd.upd_mispred};
`endif

endmodule

// File: tb/tb_bpu.sv
// tb_bpu: directed table-driven bench for bpu (IDX_BITS=6).
// Each vector drives pc_i and an optional update in one cycle; pr/pr_addr
// are checked at the falling edge, i.e. against the state before the update
// of that cycle lands.
module tb_bpu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pr;
  logic [31:0] pr_addr;
`ifdef BPU_PERF_EN
  logic [31:0] perf_upd, perf_mispred;
`endif

  bpu_if u_if ();

  bpu #(.IDX_BITS(6)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef BPU_PERF_EN
    .perf_upd     (perf_upd),
    .perf_mispred (perf_mispred),
`endif
    .pc_i    (pc_i),
    .pr      (pr),
    .pr_addr (pr_addr),
    .upd     (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        exp_pr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [31:0] pc, logic uv, logic [31:0] upc, logic ut,
                              logic [31:0] utgt, logic ep, logic [31:0] ea);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.exp_pr = ep; v.exp_addr = ea;
    return v;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic mp);
    @(posedge clk); #1;
    pc_i             = pc;
    u_if.upd_valid   = uv;
    u_if.upd_pc      = upc;
    u_if.upd_taken   = ut;
    u_if.upd_target  = utgt;
    u_if.upd_mispred = mp;
  endtask

  task automatic idle_check(input string name, input logic [31:0] pc,
                            input logic ep, input logic [31:0] ea);
    drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk({name, " pr"}, {31'h0, pr}, {31'h0, ep});
    chk({name, " addr"}, pr_addr, ea);
  endtask

  initial begin
    // cold
    vt.push_back(mk(32'h100, 0, 0,      0, 0,      0, 0));
    // allocate 0x100 -> 0x200, cnt WT
    vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0));
    vt.push_back(mk(32'h100, 0, 0,      0, 0,      1, 32'h200));
    vt.push_back(mk(32'h104, 0, 0,      0, 0,      0, 0));
    // not taken -> WNT
    vt.push_back(mk(32'h100, 1, 32'h100, 0, 0,      1, 32'h200));
    vt.push_back(mk(32'h100, 0, 0,      0, 0,      0, 0));
    // taken -> WT
    vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0));
    vt.push_back(mk(32'h100, 0, 0,      0, 0,      1, 32'h200));
    // 5 taken: saturates at ST
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200));
    // NT: ST -> WT, still predicts
    vt.push_back(mk(32'h100, 1, 32'h100, 0, 0,      1, 32'h200));
    vt.push_back(mk(32'h100, 0, 0,      0, 0,      1, 32'h200));
    // NT: WT -> WNT
    vt.push_back(mk(32'h100, 1, 32'h100, 0, 0,      1, 32'h200));
    vt.push_back(mk(32'h100, 0, 0,      0, 0,      0, 0));
    // back to WT
    vt.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0));
    vt.push_back(mk(32'h100, 0, 0,      0, 0,      1, 32'h200));
    // aliasing + same-cycle update: 0x200 misses this cycle, replaces idx 0
    vt.push_back(mk(32'h200, 1, 32'h200, 1, 32'h300, 0, 0));
    vt.push_back(mk(32'h200, 0, 0,      0, 0,      1, 32'h300));
    vt.push_back(mk(32'h100, 0, 0,      0, 0,      0, 0));
    // not-taken miss leaves the entry alone
    vt.push_back(mk(32'h200, 1, 32'h100, 0, 0,      1, 32'h300));
    vt.push_back(mk(32'h200, 0, 0,      0, 0,      1, 32'h300));
    // taken hit retargets
    vt.push_back(mk(32'h200, 1, 32'h200, 1, 32'h400, 1, 32'h300));
    vt.push_back(mk(32'h200, 0, 0,      0, 0,      1, 32'h400));
    // low PC bits ignored
    vt.push_back(mk(32'h203, 0, 0,      0, 0,      1, 32'h400));
    // top index, tag 0
    vt.push_back(mk(32'h0FC, 1, 32'h0FC, 1, 32'h1234, 0, 0));
    vt.push_back(mk(32'h0FC, 0, 0,      0, 0,      1, 32'h1234));

    rst = 1'b1;
    pc_i = 32'h100;
    u_if.upd_valid = 1'b0; u_if.upd_pc = '0; u_if.upd_taken = 1'b0;
    u_if.upd_target = '0; u_if.upd_mispred = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst pr", {31'h0, pr}, 32'h0);
    chk("rst addr", pr_addr, 32'h0);
`ifdef BPU_PERF_EN
    chk("rst perf_upd", perf_upd, 32'h0);
    chk("rst perf_mis", perf_mispred, 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].pc, vt[i].uv, vt[i].upc, vt[i].ut, vt[i].utgt, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d pr", i), {31'h0, pr}, {31'h0, vt[i].exp_pr});
      chk($sformatf("v%0d addr", i), pr_addr, vt[i].exp_addr);
    end

    // reset mid-operation: train 0x100, then reset with a live update
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    idle_check("mid train", 32'h100, 1'b1, 32'h200);
    drive(32'h104, 1'b1, 32'h104, 1'b1, 32'h500, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    u_if.upd_valid = 1'b0;
    @(negedge clk);
    chk("mid rst 0x104 pr", {31'h0, pr}, 32'h0);
    idle_check("mid rst 0x100", 32'h100, 1'b0, 32'h0);
    idle_check("mid rst 0x0fc", 32'h0FC, 1'b0, 32'h0);
`ifdef BPU_PERF_EN
    chk("perf_upd zero", perf_upd, 32'h0);
    chk("perf_mis zero", perf_mispred, 32'h0);
    drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    drive(32'h0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1);
    drive(32'h0, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0);
    drive(32'h0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
    @(negedge clk);
    chk("perf_upd 3", perf_upd, 32'd3);
    chk("perf_mis 1", perf_mispred, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
